// File: rtl/mem_bist.sv
// BIST initiator for the mem block: writes a seeded LFSR pattern, reads it back and compares.
// Define MEM_BIST_INV_PASS_EN to append a second write/read pass with inverted data.
module mem_bist #(
   parameter int          DW     = 64,
   parameter int          AW     = 5,
   parameter int          RD_LAT = 1,
   parameter logic [31:0] SEED   = 32'h0000_07AC
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [AW+1:0] err_count,
   output logic [AW-1:0] first_err_addr,
   output logic          mem_mode,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_data_in,
   input  logic [DW-1:0] mem_data_out
);

   localparam logic [31:0] POLY     = 32'h8020_0003;
   localparam logic [31:0] SEED_EFF = (SEED == 32'h0) ? 32'h1 : SEED;
   localparam int          DCW      = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
`ifdef MEM_BIST_INV_PASS_EN
   localparam bit INV_EN = 1'b1;
`else
   localparam bit INV_EN = 1'b0;
`endif

   typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, DONE} state_t;

   function automatic logic [31:0] lfsr_step(input logic [31:0] x);
      return {1'b0, x[31:1]} ^ (x[0] ? POLY : 32'h0);
   endfunction

   // {lfsr, ~lfsr}, optionally inverted, truncated or zero-extended to DW
   function automatic logic [DW-1:0] pattern(input logic [31:0] l, input logic inv);
      logic [63:0]   w;
      logic [DW-1:0] r;
      w = inv ? ~{l, ~l} : {l, ~l};
      for (int i = 0; i < DW; i++) begin
         r[i] = (i < 64) ? w[i[5:0]] : 1'b0;
      end
      return r;
   endfunction

   state_t          state_q, state_d;
   logic [31:0]     lfsr_q, lfsr_d, lfsr_nx;
   logic            inv_q, inv_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdat_q, wdat_d;
   logic            mode_q, mode_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;
   logic [AW+1:0]   err_q, err_d;
   logic [AW-1:0]   ferr_q, ferr_d;
   logic [DCW-1:0]  dcnt_q, dcnt_d;

   logic            pv_q [RD_LAT];
   logic [DW-1:0]   pe_q [RD_LAT];
   logic [AW-1:0]   pa_q [RD_LAT];
   logic            cmp_mis;

   assign cmp_mis = pv_q[RD_LAT-1] && (pe_q[RD_LAT-1] != mem_data_out);
   assign lfsr_nx = lfsr_step(lfsr_q);

   always_comb begin
      state_d = state_q;
      lfsr_d  = lfsr_q;
      inv_d   = inv_q;
      addr_d  = addr_q;
      wdat_d  = '0;
      dcnt_d  = dcnt_q;
      pass_d  = pass_q;
      err_d   = err_q;
      ferr_d  = ferr_q;

      if (cmp_mis) begin
         if (err_q != '1) err_d = err_q + (AW+2)'(1);
         if (err_q == '0) ferr_d = pa_q[RD_LAT-1];
      end

      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = WRITE;
               lfsr_d  = SEED_EFF;
               inv_d   = 1'b0;
               addr_d  = '0;
               wdat_d  = pattern(SEED_EFF, 1'b0);
               err_d   = '0;
               ferr_d  = '0;
               pass_d  = 1'b0;
            end
         end
         WRITE: begin
            if (addr_q == '1) begin
               state_d = READ;
               lfsr_d  = SEED_EFF;
               addr_d  = '0;
            end else begin
               lfsr_d  = lfsr_nx;
               addr_d  = addr_q + AW'(1);
               wdat_d  = pattern(lfsr_nx, inv_q);
            end
         end
         READ: begin
            if (addr_q == '1) begin
               state_d = DRAIN;
               addr_d  = '0;
               dcnt_d  = '0;
            end else begin
               lfsr_d  = lfsr_nx;
               addr_d  = addr_q + AW'(1);
            end
         end
         DRAIN: begin
            if (dcnt_q == DCW'(RD_LAT-1)) begin
               if (INV_EN && !inv_q) begin
                  state_d = WRITE;
                  inv_d   = 1'b1;
                  lfsr_d  = SEED_EFF;
                  addr_d  = '0;
                  wdat_d  = pattern(SEED_EFF, 1'b1);
               end else begin
                  state_d = DONE;
                  pass_d  = (err_d == '0);
               end
            end else begin
               dcnt_d = dcnt_q + DCW'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      mode_d = (state_d != WRITE);
      busy_d = (state_d != IDLE);
      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         lfsr_q  <= SEED_EFF;
         inv_q   <= 1'b0;
         addr_q  <= '0;
         wdat_q  <= '0;
         mode_q  <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         err_q   <= '0;
         ferr_q  <= '0;
         dcnt_q  <= '0;
         for (int i = 0; i < RD_LAT; i++) begin
            pv_q[i] <= 1'b0;
            pe_q[i] <= '0;
            pa_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         lfsr_q  <= lfsr_d;
         inv_q   <= inv_d;
         addr_q  <= addr_d;
         wdat_q  <= wdat_d;
         mode_q  <= mode_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         err_q   <= err_d;
         ferr_q  <= ferr_d;
         dcnt_q  <= dcnt_d;
         // expected word and address travel alongside the read latency
         pv_q[0] <= (state_q == READ);
         pe_q[0] <= pattern(lfsr_q, inv_q);
         pa_q[0] <= addr_q;
         for (int i = 1; i < RD_LAT; i++) begin
            pv_q[i] <= pv_q[i-1];
            pe_q[i] <= pe_q[i-1];
            pa_q[i] <= pa_q[i-1];
         end
      end
   end

   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_count      = err_q;
   assign first_err_addr = ferr_q;
   assign mem_mode       = mode_q;
   assign mem_addr       = addr_q;
   assign mem_data_in    = wdat_q;

endmodule

// File: tb/tb_mem_bist.sv
// Bench for mem_bist: table of fault scenarios, random faults against a reference model, reset corner case.
module tb_mem_bist;

   localparam int D = 32;
`ifdef MEM_BIST_INV_PASS_EN
   localparam int NP = 2;
`else
   localparam int NP = 1;
`endif
   localparam int L1      = 2*D + 1;
   localparam int DONE_K  = NP*L1 + 1;
   localparam int DONE2_K = NP*(2*D + 2) + 1;
   localparam logic [31:0] POLY = 32'h8020_0003;

   logic        clk, reset, start;
   logic        busy, done, pass, mem_mode;
   logic [6:0]  err_count;
   logic [4:0]  first_err_addr, mem_addr;
   logic [63:0] mem_data_in, mem_data_out;
   logic        busy2, done2, pass2, mem_mode2;
   logic [6:0]  err_count2;
   logic [4:0]  first_err_addr2, mem_addr2;
   logic [63:0] mem_data_in2, mem_data_out2;

   int total = 0;
   int bad   = 0;

   mem_bist dut (
      .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done), .pass(pass),
      .err_count(err_count), .first_err_addr(first_err_addr), .mem_mode(mem_mode),
      .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out));

   mem_bist #(.RD_LAT(2)) dut2 (
      .clk(clk), .reset(reset), .start(start), .busy(busy2), .done(done2), .pass(pass2),
      .err_count(err_count2), .first_err_addr(first_err_addr2), .mem_mode(mem_mode2),
      .mem_addr(mem_addr2), .mem_data_in(mem_data_in2), .mem_data_out(mem_data_out2));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // memory models: read value = (stored & and_m) | or_m
   logic [63:0] mem1 [D];
   logic [63:0] and_m [D];
   logic [63:0] or_m [D];
   logic [63:0] rd1_q;
   logic [63:0] mem2 [D];
   logic [63:0] r2a_q, r2b_q;

   always @(posedge clk) begin
      if (!mem_mode) mem1[mem_addr] <= mem_data_in;
      rd1_q <= (mem1[mem_addr] & and_m[mem_addr]) | or_m[mem_addr];
      if (!mem_mode2) mem2[mem_addr2] <= mem_data_in2;
      r2a_q <= mem2[mem_addr2];
      r2b_q <= r2a_q;
   end
   assign mem_data_out  = rd1_q;
   assign mem_data_out2 = r2b_q;

   logic [31:0] lfsr_tab [D];

   function automatic logic [31:0] lfsr_adv(input logic [31:0] x);
      logic o;
      o = x[0];
      x = x >> 1;
      if (o) x = x ^ POLY;
      return x;
   endfunction

   function automatic logic [63:0] pat(input int a, input int p);
      logic [63:0] w;
      w = {lfsr_tab[a], ~lfsr_tab[a]};
      return (p != 0) ? ~w : w;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic set_ideal();
      for (int a = 0; a < D; a++) begin
         and_m[a] = '1;
         or_m[a]  = '0;
      end
   endtask

   // errors in time order: pass by pass, ascending address, saturating at 127
   task automatic ref_eval(output bit xp, output int xe, output int xf);
      logic [63:0] w, obs;
      xe = 0;
      xf = 0;
      for (int p = 0; p < NP; p++) begin
         for (int a = 0; a < D; a++) begin
            w   = pat(a, p);
            obs = (w & and_m[a]) | or_m[a];
            if (obs != w) begin
               if (xe == 0) xf = a;
               if (xe < 127) xe++;
            end
         end
      end
      xp = (xe == 0);
   endtask

   task automatic run_vec(input string nm, input bit glitch, input bit xp, input int xe, input int xf);
      int k1, k2, extra, sched_bad, busy_bad, r, p;
      logic [63:0] first_wr, held_pass;
      logic got_pass, got_pass2;
      logic [6:0] got_err;
      logic [4:0] got_first;
      k1 = -1; k2 = -1; extra = 0; sched_bad = 0; busy_bad = 0;
      first_wr = '0; held_pass = '0;
      got_pass = 1'b0; got_pass2 = 1'b0; got_err = '0; got_first = '0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int k = 1; k <= DONE2_K + 1; k++) begin
         if (k == 1) first_wr = {mem_addr == 5'd0, 63'b0} | mem_data_in;
         if (k1 < 0 || k <= k1) begin
            if (!busy) busy_bad++;
            if (k <= NP*L1) begin
               r = (k - 1) % L1;
               p = (k - 1) / L1;
               if (r < D) begin
                  if (mem_mode !== 1'b0 || mem_addr !== 5'(r) || mem_data_in !== pat(r, p)) sched_bad++;
               end else if (r < 2*D) begin
                  if (mem_mode !== 1'b1 || mem_addr !== 5'(r - D)) sched_bad++;
               end
            end
         end
         if (done) begin
            if (k1 < 0) begin
               k1 = k;
               got_pass = pass; got_err = err_count; got_first = first_err_addr;
            end else extra++;
         end
         if (k1 > 0 && k == k1 + 1) begin
            held_pass = {62'b0, busy | done, pass};
         end
         if (done2) begin
            if (k2 < 0) begin
               k2 = k;
               got_pass2 = pass2;
            end else extra++;
         end
         if (glitch) start = (k == 10);
         @(negedge clk);
      end
      start = 1'b0;
      chk({nm, "/first_write"}, first_wr, 64'h8000_07AC_FFFF_F853);
      chk({nm, "/schedule_errs"}, 64'(sched_bad), 64'd0);
      chk({nm, "/busy_errs"}, 64'(busy_bad), 64'd0);
      chk({nm, "/done_cycle"}, 64'(k1), 64'(DONE_K));
      chk({nm, "/extra_done"}, 64'(extra), 64'd0);
      chk({nm, "/pass"}, 64'(got_pass), 64'(xp));
      chk({nm, "/err_count"}, 64'(got_err), 64'(xe));
      chk({nm, "/first_err"}, 64'(got_first), 64'(xf));
      chk({nm, "/idle_pass_held"}, held_pass, {62'b0, 1'b0, xp});
      chk({nm, "/lat2_done_cycle"}, 64'(k2), 64'(DONE2_K));
      chk({nm, "/lat2_pass"}, 64'(got_pass2), 64'd1);
   endtask

   typedef struct {
      string nm;
      int    kind;   // 0 ideal, 1 all-zero reads, 2 or-mask on one address
      int    faddr;
      logic [63:0] fmask;
      bit    glitch;
      bit    xp;
      int    xe;
      int    xf;
   } vec_t;

   vec_t vecs [5];

   initial begin
      bit xp;
      int xe, xf;
      int ndone;
      logic [31:0] l;

      l = 32'h0000_07AC;
      for (int a = 0; a < D; a++) begin
         lfsr_tab[a] = l;
         l = lfsr_adv(l);
      end
      set_ideal();

      vecs[0] = '{"ideal",       0, 0,  64'h0,         1'b0, 1'b1, 0,    0};
      vecs[1] = '{"stuck_a5b32", 2, 5,  64'h1 << 32,   1'b0, 1'b0, 1,    5};
      vecs[2] = '{"all_zero",    1, 0,  64'h0,         1'b0, 1'b0, 32*NP, 0};
      vecs[3] = '{"start_busy",  0, 0,  64'h0,         1'b1, 1'b1, 0,    0};
      vecs[4] = '{"ones_a17",    2, 17, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, NP, 17};

      reset = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst/busy", 64'(busy), 64'd0);
      chk("rst/done", 64'(done), 64'd0);
      chk("rst/pass", 64'(pass), 64'd0);
      chk("rst/err_count", 64'(err_count), 64'd0);
      chk("rst/first_err", 64'(first_err_addr), 64'd0);
      chk("rst/mem_mode", 64'(mem_mode), 64'd1);
      chk("rst/mem_addr", 64'(mem_addr), 64'd0);
      chk("rst/mem_data_in", mem_data_in, 64'd0);
      reset = 1'b0;

      for (int i = 0; i < 5; i++) begin
         set_ideal();
         if (vecs[i].kind == 1) begin
            for (int a = 0; a < D; a++) and_m[a] = '0;
         end else if (vecs[i].kind == 2) begin
            or_m[vecs[i].faddr] = vecs[i].fmask;
         end
         run_vec(vecs[i].nm, vecs[i].glitch, vecs[i].xp, vecs[i].xe, vecs[i].xf);
      end

      for (int n = 0; n < 6; n++) begin
         set_ideal();
         for (int a = 0; a < D; a++) begin
            case ($urandom_range(0, 7))
               0: or_m[a]  = 64'h1 << $urandom_range(0, 63);
               1: and_m[a] = ~(64'h1 << $urandom_range(0, 63));
               default: ;
            endcase
         end
         ref_eval(xp, xe, xf);
         run_vec($sformatf("rand%0d", n), 1'b0, xp, xe, xf);
      end

      // reset in the middle of READ with every read failing
      set_ideal();
      for (int a = 0; a < D; a++) and_m[a] = '0;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (39) @(negedge clk);
      chk("midrst/err_before", 64'(err_count), 64'd6);
      chk("midrst/busy_before", 64'(busy), 64'd1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("midrst/busy", 64'(busy), 64'd0);
      chk("midrst/mem_mode", 64'(mem_mode), 64'd1);
      chk("midrst/mem_addr", 64'(mem_addr), 64'd0);
      chk("midrst/err_count", 64'(err_count), 64'd0);
      chk("midrst/first_err", 64'(first_err_addr), 64'd0);
      ndone = 0;
      for (int k = 0; k < 150; k++) begin
         if (done || done2) ndone++;
         @(negedge clk);
      end
      chk("midrst/no_done", 64'(ndone), 64'd0);
      set_ideal();
      run_vec("after_rst", 1'b0, 1'b1, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
